game_tick_pacer: RTL and testbench

Consumer side of the game-tick interface. It takes the `game_tick` square wave, which toggles once every 1,000,000 cycles of `clk_100mhz`, and turns every toggle into a single-cycle tick event. It divides those events by a runtime speed setting to produce game-step pulses, and supports run, pause and idle control. A watchdog flags a stalled tick source. The game FSM and renderer consume its outputs.

---
 rtl/game_pkg.sv | 26 ++
 rtl/tick_edge_detect.sv | 38 +++
 rtl/game_tick_pacer.sv | 145 ++++++++++++++
 tb/tb_game_tick_pacer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game-tick consumer logic: pacer state encoding,
// the nominal tick period and the default watchdog limit.
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // game_tick toggles once per this many clk_100mhz cycles.
  localparam int TICK_CYCLES = 1000000;

  // 2.5 nominal tick periods of silence before the source is declared stalled.
  localparam int WATCHDOG_LIMIT_DEFAULT = 2500000;

  // States in which the tick source is expected to be alive.
  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// ---------------------------------------------------------------------------
// tick_edge_detect
// Turns every level change of the game_tick square wave into a tick event.
//   clk_100mhz  in   system clock
//   reset       in   synchronous, active-high
//   game_tick   in   tick square wave, same clock domain
//   tick_event  out  combinational: game_tick differs from its registered copy
//   tick_pulse  out  registered tick_event, one cycle after the input change
// ---------------------------------------------------------------------------
module tick_edge_detect (
  input  logic clk_100mhz,
  input  logic reset,
  input  logic game_tick,
  output logic tick_event,
  output logic tick_pulse
);

  logic tick_q;
  logic tick_pulse_q;

  // The tick source also resets to 0, so clearing tick_q here means no
  // spurious event appears when reset is released.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      tick_q       <= 1'b0;
      tick_pulse_q <= 1'b0;
    end else begin
      tick_q       <= game_tick;
      tick_pulse_q <= tick_event;
    end
  end

  assign tick_event = game_tick ^ tick_q;
  assign tick_pulse = tick_pulse_q;

endmodule

// File: rtl/game_tick_pacer.sv
// ---------------------------------------------------------------------------
// game_tick_pacer
// Consumer side of the game-tick interface. Converts game_tick toggles into
// tick pulses, divides them by a runtime speed setting into game steps, and
// handles run / pause / idle control plus a stalled-source watchdog.
//   clk_100mhz  in   system clock, 100 MHz
//   reset       in   synchronous, active-high
//   game_tick   in   tick square wave; each level change is one tick event
//   enable      in   1 = game active, 0 forces IDLE
//   pause       in   level; 1 freezes stepping while enabled
//   speed       in   step divisor minus 1, sampled on each tick event
//   tick_pulse  out  one-cycle pulse per game_tick toggle (all states)
//   step_pulse  out  one-cycle game-step pulse
//   step_count  out  steps issued since entering RUN from IDLE (wraps)
//   paused      out  1 while in PAUSE
//   tick_fault  out  1 while in FAULT
// ---------------------------------------------------------------------------
module game_tick_pacer
  import game_pkg::*;
#(
  parameter int SPEED_BITS     = 3,
  parameter int COUNT_BITS     = 16,
  parameter int WATCHDOG_LIMIT = WATCHDOG_LIMIT_DEFAULT,
  parameter int WD_BITS        = 22
) (
  input  logic                  clk_100mhz,
  input  logic                  reset,
  input  logic                  game_tick,
  input  logic                  enable,
  input  logic                  pause,
  input  logic [SPEED_BITS-1:0] speed,
  output logic                  tick_pulse,
  output logic                  step_pulse,
  output logic [COUNT_BITS-1:0] step_count,
  output logic                  paused,
  output logic                  tick_fault
);

  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(WATCHDOG_LIMIT);

  state_e                  state_q, state_d;
  logic [SPEED_BITS-1:0]   div_cnt_q, div_cnt_d;
  logic [COUNT_BITS-1:0]   step_count_q, step_count_d;
  logic [WD_BITS-1:0]      wd_q, wd_d;
  logic                    step_pulse_q, step_pulse_d;
  logic                    paused_q, paused_d;
  logic                    fault_q, fault_d;
  logic                    tick_event;
  logic                    wd_at_limit;
  logic                    run_event;

  tick_edge_detect u_edge (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .game_tick  (game_tick),
    .tick_event (tick_event),
    .tick_pulse (tick_pulse)
  );

  // The watchdog never runs past the limit: reaching it leaves RUN/PAUSE,
  // which clears the counter, so an exact compare is sufficient.
  assign wd_at_limit = (wd_q == WD_LIMIT);

  // State register.
  always_ff @(posedge clk_100mhz) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; enable=0 overrides everything except reset.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   if (wd_at_limit) state_d = ST_FAULT;
                  else if (pause)  state_d = ST_PAUSE;
        ST_PAUSE: if (wd_at_limit) state_d = ST_FAULT;
                  else if (!pause) state_d = ST_RUN;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // A tick only advances the divider when we are in RUN and staying there;
  // an event that coincides with pause, fault or disable is swallowed.
  assign run_event = tick_event && (state_q == ST_RUN) && (state_d == ST_RUN);

  // Output / datapath next-state logic.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    step_count_d = step_count_q;
    step_pulse_d = 1'b0;
    wd_d         = '0;
    paused_d     = (state_d == ST_PAUSE);
    fault_d      = (state_d == ST_FAULT);

    if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      div_cnt_d    = '0;
      step_count_d = '0;
    end else if (run_event) begin
      // >= rather than == so that lowering speed mid-count steps at once.
      if (div_cnt_q >= speed) begin
        step_pulse_d = 1'b1;
        div_cnt_d    = '0;
        step_count_d = step_count_q + COUNT_BITS'(1);
      end else begin
        div_cnt_d    = div_cnt_q + SPEED_BITS'(1);
      end
    end

    // Count quiet cycles only while the source is expected to be alive.
    if (is_active(state_q) && is_active(state_d) && !tick_event)
      wd_d = wd_q + WD_BITS'(1);
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      div_cnt_q    <= '0;
      step_count_q <= '0;
      wd_q         <= '0;
      step_pulse_q <= 1'b0;
      paused_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      step_count_q <= step_count_d;
      wd_q         <= wd_d;
      step_pulse_q <= step_pulse_d;
      paused_q     <= paused_d;
      fault_q      <= fault_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_count = step_count_q;
  assign paused     = paused_q;
  assign tick_fault = fault_q;

endmodule

// File: tb/tb_game_tick_pacer.sv
// ---------------------------------------------------------------------------
// tb_game_tick_pacer
// Directed scenarios followed by a randomized phase; a behavioural model of
// the pacer predicts every output and is compared each cycle.
// ---------------------------------------------------------------------------
module tb_game_tick_pacer;

  localparam int LIMIT = 50;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FAULT = 3;

  logic        clk_100mhz;
  logic        reset;
  logic        game_tick;
  logic        enable;
  logic        pause;
  logic [2:0]  speed;
  logic        tick_pulse;
  logic        step_pulse;
  logic [15:0] step_count;
  logic        paused;
  logic        tick_fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic preload_req = 1'b0;

  game_tick_pacer #(
    .SPEED_BITS     (3),
    .COUNT_BITS     (16),
    .WATCHDOG_LIMIT (LIMIT),
    .WD_BITS        (22)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .game_tick  (game_tick),
    .enable     (enable),
    .pause      (pause),
    .speed      (speed),
    .tick_pulse (tick_pulse),
    .step_pulse (step_pulse),
    .step_count (step_count),
    .paused     (paused),
    .tick_fault (tick_fault)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode = M_IDLE;
  int          m_div = 0;
  int          m_quiet = 0;   // cycles since last event while source expected alive
  logic [15:0] m_count = '0;
  logic        m_level = 1'b0;
  logic        m_tick = 1'b0, m_step = 1'b0, m_paused = 1'b0, m_fault = 1'b0;

  function automatic logic alive(input int md);
    return (md == M_RUN) || (md == M_PAUSE);
  endfunction

  always @(posedge clk_100mhz) begin : ref_model
    logic ev;
    logic stepping;
    int   nxt;
    if (reset) begin
      m_mode <= M_IDLE; m_div <= 0; m_quiet <= 0; m_count <= '0; m_level <= 1'b0;
      m_tick <= 1'b0; m_step <= 1'b0; m_paused <= 1'b0; m_fault <= 1'b0;
    end else begin
      ev = (game_tick != m_level);
      if (!enable)                 nxt = M_IDLE;
      else if (m_mode == M_IDLE)   nxt = M_RUN;
      else if (m_mode == M_FAULT)  nxt = M_FAULT;
      else if (m_quiet == LIMIT)   nxt = M_FAULT;
      else                         nxt = pause ? M_PAUSE : M_RUN;
      stepping = ev && (m_mode == M_RUN) && (nxt == M_RUN) && (m_div >= int'(speed));
      m_level  <= game_tick;
      m_tick   <= ev;
      m_step   <= stepping;
      m_paused <= (nxt == M_PAUSE);
      m_fault  <= (nxt == M_FAULT);
      if (m_mode == M_IDLE && nxt == M_RUN) begin
        m_div <= 0; m_count <= '0;
      end else if (stepping) begin
        m_div <= 0; m_count <= m_count + 16'd1;
      end else if (ev && m_mode == M_RUN && nxt == M_RUN) begin
        m_div <= m_div + 1;
      end
      if (preload_req) m_count <= 16'hFFFF;
      m_quiet <= (alive(m_mode) && alive(nxt) && !ev) ? m_quiet + 1 : 0;
      m_mode  <= nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(negedge clk_100mhz);
    #1;
    if (chk_en) begin
      check("tick_pulse", {31'd0, tick_pulse}, {31'd0, m_tick});
      check("step_pulse", {31'd0, step_pulse}, {31'd0, m_step});
      check("step_count", {16'd0, step_count}, {16'd0, m_count});
      check("paused",     {31'd0, paused},     {31'd0, m_paused});
      check("tick_fault", {31'd0, tick_fault}, {31'd0, m_fault});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic toggle_and_wait(output logic tp, output logic sp);
    game_tick = ~game_tick;
    @(negedge clk_100mhz);
    tp = tick_pulse;
    sp = step_pulse;
    cyc(9);
  endtask

  initial begin
    logic        tp, sp;
    logic [8:0]  steps;
    logic [15:0] saved;
    int          n;
    int          since, gap;

    reset = 1'b1; game_tick = 1'b0; enable = 1'b0; pause = 1'b0; speed = '0;
    cyc(3);
    check("reset_outputs", {tick_pulse, step_pulse, step_count, paused, tick_fault}, '0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: speed 0, every toggle steps
    enable = 1'b1; speed = 3'd0;
    cyc(3);
    for (int k = 0; k < 5; k++) begin
      toggle_and_wait(tp, sp);
      check("t1_tick", {31'd0, tp}, 32'd1);
      check("t1_step", {31'd0, sp}, 32'd1);
    end
    check("t1_count5", {16'd0, step_count}, 32'd5);

    // 2: speed 2, steps on toggles 3, 6, 9; then lower speed with div at 2
    speed = 3'd2;
    for (int k = 0; k < 9; k++) begin
      toggle_and_wait(tp, sp);
      steps[k] = sp;
    end
    check("t2_pattern", {23'd0, steps}, 32'h124);
    check("t2_count8", {16'd0, step_count}, 32'd8);
    toggle_and_wait(tp, sp);
    toggle_and_wait(tp, sp);
    check("t2_no_step_div2", {31'd0, sp}, 32'd0);
    speed = 3'd0;
    toggle_and_wait(tp, sp);
    check("t2_speed_drop_step", {31'd0, sp}, 32'd1);

    // 3: pause on an edge cycle, preserved divider
    speed = 3'd2;
    toggle_and_wait(tp, sp);               // div -> 1
    game_tick = ~game_tick; pause = 1'b1;
    @(negedge clk_100mhz);
    check("t3_tick_on_pause", {31'd0, tick_pulse}, 32'd1);
    check("t3_no_step_on_pause", {31'd0, step_pulse}, 32'd0);
    check("t3_paused", {31'd0, paused}, 32'd1);
    saved = step_count;
    cyc(9);
    for (int k = 0; k < 4; k++) toggle_and_wait(tp, sp);
    check("t3_frozen", {16'd0, step_count}, {16'd0, saved});
    pause = 1'b0;
    cyc(5);
    toggle_and_wait(tp, sp);
    check("t3_resume_div2", {31'd0, sp}, 32'd0);
    toggle_and_wait(tp, sp);
    check("t3_resume_step", {31'd0, sp}, 32'd1);

    // 4: stall -> fault 51 cycles after the last tick pulse
    game_tick = ~game_tick;
    @(negedge clk_100mhz);
    n = 0;
    while (n < 200 && !tick_fault) begin
      @(negedge clk_100mhz);
      n++;
    end
    check("t4_fault_latency", n, 32'd51);
    for (int k = 0; k < 3; k++) begin
      toggle_and_wait(tp, sp);
      check("t4_fault_held", {31'd0, tick_fault}, 32'd1);
    end
    enable = 1'b0;
    @(negedge clk_100mhz);
    check("t4_fault_cleared", {31'd0, tick_fault}, 32'd0);
    enable = 1'b1;
    cyc(2);
    check("t4_count_cleared", {16'd0, step_count}, 32'd0);

    // 5: wrap of step_count, disable on an edge cycle
    speed = 3'd0;
    cyc(5);
    chk_en = 1'b0; preload_req = 1'b1;
    force dut.step_count_q = 16'hFFFF;
    @(negedge clk_100mhz);
    release dut.step_count_q;
    preload_req = 1'b0; chk_en = 1'b1;
    check("t5_preload", {16'd0, step_count}, 32'hFFFF);
    toggle_and_wait(tp, sp);
    check("t5_wrap_step", {31'd0, sp}, 32'd1);
    check("t5_wrapped", {16'd0, step_count}, 32'd0);
    game_tick = ~game_tick; enable = 1'b0;
    @(negedge clk_100mhz);
    check("t5_tick_on_disable", {31'd0, tick_pulse}, 32'd1);
    check("t5_no_step_on_disable", {31'd0, step_pulse}, 32'd0);
    cyc(5);

    // 6: reset mid-run with div at 1
    enable = 1'b1; speed = 3'd3;
    cyc(3);
    toggle_and_wait(tp, sp);
    reset = 1'b1; game_tick = 1'b0;
    @(negedge clk_100mhz);
    check("t6_reset_outputs", {tick_pulse, step_pulse, step_count, paused, tick_fault}, '0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100mhz);
      check("t6_no_tick_after_reset", {31'd0, tick_pulse}, 32'd0);
    end

    // randomized phase
    since = 0; gap = 5;
    for (int i = 0; i < 4000; i++) begin
      if (since >= gap) begin
        game_tick = ~game_tick;
        since = 0;
        gap = ($urandom_range(0, 59) == 0) ? $urandom_range(55, 70) : $urandom_range(2, 14);
      end
      if ($urandom_range(0, 99) == 0)  pause  = ~pause;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0)  speed  = 3'($urandom);
      @(negedge clk_100mhz);
      since++;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
